unidade_controle: RTL and testbench

Multicycle control FSM that drives every control input of the MIPS-subset datapath `cpu` (PC/A/B/IR/EPC/Flag write enables, ALU/mux selects, shifter and memory controls).
It consumes decoded instruction fields, ALU flags and the branch-condition bit, and produces the control wires each cycle.
It is the producer end of the control interface that the datapath consumes.

---
 rtl/unidade_controle.sv | 336 +++++++++++++++++++++++++++++++++
 tb/tb_unidade_controle.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/unidade_controle.sv
// -----------------------------------------------------------------------------
// unidade_controle
// Multicycle control FSM for the MIPS-subset datapath "cpu". Each cycle it
// decodes the current state (Moore style) into every datapath control wire:
// write enables, ALU operand/operation selects, shifter controls, memory
// address source and PC source.
//
// Optional feature macro: UNIDADE_CONTROLE_EXC_EN
//   defined   : unknown opcode/funct and ALU overflow on add/sub/addi raise an
//               exception (save EPC, read handler address, jump to it).
//   undefined : unknown instructions act as NOP, overflow is ignored.
//
// Parameter
//   MEM_WAIT  cycles a memory read is held stable before sampling (1..7)
//
// Ports
//   clk, reset           clock, synchronous active-high reset
//   opcode, funct        IR[31:26], IR[5:0]
//   overflow             ALU overflow (exception build only)
//   cond                 branch condition from the conSrc mux
//   *_write, IRWrite,
//   RegWrite, MemWrite,
//   FlagRegWrite         write enables
//   Seletor              ALU op (001 add, 010 sub, 111 compare)
//   seletor_ulaA/B       ALU operand selects
//   RegDst, MemtoReg     register file destination / write-back source
//   ShiftOP, SrInputSrc,
//   SrNSrc               shifter controls
//   IorD                 memory address source
//   PCSource, conSrc     PC source, branch condition select
//   load_size, store_size, SrctoMem, HiLoSrc  memory/HI-LO controls
//   state                current state encoding (debug)
// -----------------------------------------------------------------------------
module unidade_controle #(
  parameter int MEM_WAIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       overflow,
  input  logic       cond,
  output logic       PC_write,
  output logic       A_write,
  output logic       B_write,
  output logic       EPC_write,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       FlagRegWrite,
  output logic       HI_write,
  output logic       LO_write,
  output logic [2:0] Seletor,
  output logic       seletor_ulaA,
  output logic [1:0] seletor_ulaB,
  output logic [2:0] RegDst,
  output logic [3:0] MemtoReg,
  output logic [2:0] ShiftOP,
  output logic       SrInputSrc,
  output logic [1:0] SrNSrc,
  output logic [2:0] IorD,
  output logic [1:0] PCSource,
  output logic [1:0] conSrc,
  output logic [1:0] load_size,
  output logic       store_size,
  output logic       SrctoMem,
  output logic       HiLoSrc,
  output logic [5:0] state
);

  typedef enum logic [5:0] {
    S_RST         = 6'd0,
    S_FETCH       = 6'd1,
    S_FETCH_LATCH = 6'd2,
    S_DECODE      = 6'd3,
    S_R_ADD       = 6'd4,
    S_R_SUB       = 6'd5,
    S_R_SLT       = 6'd6,
    S_JR          = 6'd7,
    S_SH_LOAD     = 6'd8,
    S_SH_SLL      = 6'd9,
    S_SH_SRL      = 6'd10,
    S_SH_SRA      = 6'd11,
    S_SH_WB       = 6'd12,
    S_ADDI        = 6'd13,
    S_LUI         = 6'd14,
    S_LW_ADDR     = 6'd15,
    S_LW_WB       = 6'd16,
    S_SW          = 6'd17,
    S_BR_CMP      = 6'd18,
    S_BR_TAKE_EQ  = 6'd19,
    S_BR_TAKE_NE  = 6'd20,
    S_JMP         = 6'd21,
    S_EXC_EPC     = 6'd22,
    S_EXC_RD      = 6'd23,
    S_EXC_JMP     = 6'd24
  } state_t;

  localparam logic [2:0] WAIT_INIT = 3'(MEM_WAIT - 1);

  state_t     r_state;
  state_t     w_next;
  logic [2:0] r_wait;
  logic       w_wait_done;
  state_t     w_unknown_dst;

  assign w_wait_done = (r_wait == 3'd0);
  assign state       = r_state;

  // States that hold a memory read stable for MEM_WAIT cycles
  function automatic logic f_wait_cap(input state_t s);
    case (s)
      S_FETCH, S_LW_ADDR, S_EXC_RD: f_wait_cap = 1'b1;
      default:                      f_wait_cap = 1'b0;
    endcase
  endfunction

`ifdef UNIDADE_CONTROLE_EXC_EN
  // Cause of the pending exception: 1 = overflow, 0 = unknown instruction
  logic r_exc_ovf;
  assign w_unknown_dst = S_EXC_EPC;

  // Latch exception cause when entering the exception sequence
  always_ff @(posedge clk) begin
    if (reset) begin
      r_exc_ovf <= 1'b0;
    end else if (w_next == S_EXC_EPC && r_state != S_EXC_EPC) begin
      // only the execute states reach EXC_EPC by overflow; DECODE by opcode
      r_exc_ovf <= (r_state != S_DECODE);
    end else begin
      r_exc_ovf <= r_exc_ovf;
    end
  end
`else
  logic w_unused_ovf;
  assign w_unused_ovf  = overflow;
  assign w_unknown_dst = S_FETCH;
`endif

  // State register and memory wait counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_RST;
      r_wait  <= 3'd0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state && f_wait_cap(w_next)) begin
        r_wait <= WAIT_INIT;
      end else if (r_wait != 3'd0) begin
        r_wait <= r_wait - 3'd1;
      end else begin
        r_wait <= r_wait;
      end
    end
  end

  // Next-state logic, including instruction dispatch from DECODE
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RST:         w_next = S_FETCH;
      S_FETCH:       w_next = w_wait_done ? S_FETCH_LATCH : S_FETCH;
      S_FETCH_LATCH: w_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          6'h00: begin
            case (funct)
              6'h20:               w_next = S_R_ADD;
              6'h22:               w_next = S_R_SUB;
              6'h2a:               w_next = S_R_SLT;
              6'h08:               w_next = S_JR;
              6'h00, 6'h02, 6'h03: w_next = S_SH_LOAD;
              default:             w_next = w_unknown_dst;
            endcase
          end
          6'h08:        w_next = S_ADDI;
          6'h0f:        w_next = S_LUI;
          6'h23:        w_next = S_LW_ADDR;
          6'h2b:        w_next = S_SW;
          6'h04, 6'h05: w_next = S_BR_CMP;
          6'h02:        w_next = S_JMP;
          default:      w_next = w_unknown_dst;
        endcase
      end
`ifdef UNIDADE_CONTROLE_EXC_EN
      S_R_ADD, S_R_SUB, S_ADDI: w_next = overflow ? S_EXC_EPC : S_FETCH;
      S_EXC_EPC:                w_next = S_EXC_RD;
      S_EXC_RD:                 w_next = w_wait_done ? S_EXC_JMP : S_EXC_RD;
      S_EXC_JMP:                w_next = S_FETCH;
`else
      S_R_ADD, S_R_SUB, S_ADDI: w_next = S_FETCH;
`endif
      // shift direction is taken from funct, which the IR holds stable
      S_SH_LOAD: begin
        case (funct)
          6'h02:   w_next = S_SH_SRL;
          6'h03:   w_next = S_SH_SRA;
          default: w_next = S_SH_SLL;
        endcase
      end
      S_SH_SLL, S_SH_SRL, S_SH_SRA: w_next = S_SH_WB;
      S_LW_ADDR: w_next = w_wait_done ? S_LW_WB : S_LW_ADDR;
      S_BR_CMP:  w_next = (opcode == 6'h05) ? S_BR_TAKE_NE : S_BR_TAKE_EQ;
      S_R_SLT, S_JR, S_SH_WB, S_LUI, S_LW_WB, S_SW,
      S_BR_TAKE_EQ, S_BR_TAKE_NE, S_JMP: w_next = S_FETCH;
      default:   w_next = S_RST;
    endcase
  end

  // Moore output decode; BR_TAKE PC_write and overflow RegWrite masking
  // are the only input-dependent terms
  always_comb begin
    PC_write     = 1'b0;
    A_write      = 1'b0;
    B_write      = 1'b0;
    EPC_write    = 1'b0;
    IRWrite      = 1'b0;
    RegWrite     = 1'b0;
    MemWrite     = 1'b0;
    FlagRegWrite = 1'b0;
    HI_write     = 1'b0;
    LO_write     = 1'b0;
    Seletor      = 3'b000;
    seletor_ulaA = 1'b0;
    seletor_ulaB = 2'd0;
    RegDst       = 3'd0;
    MemtoReg     = 4'd0;
    ShiftOP      = 3'b000;
    SrInputSrc   = 1'b0;
    SrNSrc       = 2'd0;
    IorD         = 3'd0;
    PCSource     = 2'd0;
    conSrc       = 2'd0;
    load_size    = 2'd0;
    store_size   = 1'b0;
    SrctoMem     = 1'b0;
    HiLoSrc      = 1'b0;
    case (r_state)
      S_FETCH_LATCH: begin
        IRWrite      = 1'b1;
        PC_write     = 1'b1;
        seletor_ulaB = 2'd1;
        Seletor      = 3'b001;
      end
      S_DECODE: begin
        A_write = 1'b1;
        B_write = 1'b1;
      end
      S_R_ADD, S_R_SUB: begin
        seletor_ulaA = 1'b1;
        Seletor      = (r_state == S_R_SUB) ? 3'b010 : 3'b001;
        RegDst       = 3'd1;
`ifdef UNIDADE_CONTROLE_EXC_EN
        RegWrite     = ~overflow;
`else
        RegWrite     = 1'b1;
`endif
      end
      S_R_SLT: begin
        seletor_ulaA = 1'b1;
        Seletor      = 3'b111;
        MemtoReg     = 4'd9;
        RegDst       = 3'd1;
        RegWrite     = 1'b1;
      end
      S_JR: begin
        seletor_ulaA = 1'b1;
        PC_write     = 1'b1;
      end
      S_SH_LOAD: ShiftOP = 3'b001;
      S_SH_SLL:  ShiftOP = 3'b010;
      S_SH_SRL:  ShiftOP = 3'b011;
      S_SH_SRA:  ShiftOP = 3'b100;
      S_SH_WB: begin
        MemtoReg = 4'd5;
        RegDst   = 3'd1;
        RegWrite = 1'b1;
      end
      S_ADDI: begin
        seletor_ulaA = 1'b1;
        seletor_ulaB = 2'd2;
        Seletor      = 3'b001;
`ifdef UNIDADE_CONTROLE_EXC_EN
        RegWrite     = ~overflow;
`else
        RegWrite     = 1'b1;
`endif
      end
      S_LUI: begin
        MemtoReg = 4'd7;
        RegWrite = 1'b1;
      end
      S_LW_ADDR, S_LW_WB, S_SW: begin
        seletor_ulaA = 1'b1;
        seletor_ulaB = 2'd2;
        Seletor      = 3'b001;
        IorD         = 3'd1;
        MemtoReg     = (r_state == S_LW_WB) ? 4'd1 : 4'd0;
        RegWrite     = (r_state == S_LW_WB);
        MemWrite     = (r_state == S_SW);
      end
      S_BR_CMP: begin
        seletor_ulaA = 1'b1;
        Seletor      = 3'b111;
        FlagRegWrite = 1'b1;
      end
      S_BR_TAKE_EQ, S_BR_TAKE_NE: begin
        seletor_ulaB = 2'd3;
        Seletor      = 3'b001;
        conSrc       = (r_state == S_BR_TAKE_NE) ? 2'd1 : 2'd0;
        PC_write     = cond;
      end
      S_JMP: begin
        PCSource = 2'd1;
        PC_write = 1'b1;
      end
`ifdef UNIDADE_CONTROLE_EXC_EN
      S_EXC_EPC: begin
        seletor_ulaB = 2'd1;
        Seletor      = 3'b010;
        EPC_write    = 1'b1;
      end
      S_EXC_RD:  IorD = r_exc_ovf ? 3'd3 : 3'd2;
      S_EXC_JMP: begin
        load_size = 2'd2;
        PCSource  = 2'd2;
        PC_write  = 1'b1;
      end
`endif
      default: begin
        PC_write = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_unidade_controle.sv
// -----------------------------------------------------------------------------
// tb_unidade_controle
// Table-driven bench for unidade_controle. Three instances (MEM_WAIT = 1, 2, 3)
// share the same inputs; each vector names the instance it checks and carries
// the full expected control word, built from per-state expectations.
// -----------------------------------------------------------------------------
module tb_unidade_controle;

  typedef struct packed {
    logic       pc_w, a_w, b_w, epc_w, ir_w, reg_w, mem_w, flag_w, hi_w, lo_w;
    logic [2:0] sel;
    logic       ula_a;
    logic [1:0] ula_b;
    logic [2:0] reg_dst;
    logic [3:0] m2r;
    logic [2:0] sh_op;
    logic       sr_in;
    logic [1:0] sr_n;
    logic [2:0] iord;
    logic [1:0] pcsrc;
    logic [1:0] consrc;
    logic [1:0] ld_size;
    logic       st_size, src2mem, hilo;
  } ctl_t;

  typedef struct packed {
    logic       rst;
    logic [5:0] op;
    logic [5:0] fn;
    logic       cnd;
    logic       ovf;
    logic [1:0] inst;
    ctl_t       e;
    logic [1:0] sm;   // 0 state unchecked, 1 state must be 0, 2 state must be nonzero
  } vec_t;

  localparam int E_ZERO = 0,  E_LATCH = 1,  E_DECODE = 2, E_ADD = 3,  E_SUB = 4;
  localparam int E_SLT = 5,   E_JR = 6,     E_SHLOAD = 7, E_SLL = 8,  E_SRL = 9;
  localparam int E_SRA = 10,  E_SHWB = 11,  E_ADDI = 12,  E_LUI = 13, E_LWA = 14;
  localparam int E_LWWB = 15, E_SW = 16,    E_BRCMP = 17, E_BEQ = 18, E_BNE = 19;
  localparam int E_J = 20,    E_EPC = 21,   E_RD = 22,    E_EJMP = 23;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h00;
  logic       overflow = 1'b0;
  logic       cond = 1'b0;

  ctl_t       act [3];
  logic [5:0] st  [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic pcw, aw, bw, epcw, irw, rgw, mw, fw, hw, low;
    logic [2:0] sel;
    logic       ua;
    logic [1:0] ub;
    logic [2:0] rd;
    logic [3:0] m2r;
    logic [2:0] sop;
    logic       sri;
    logic [1:0] srn;
    logic [2:0] iord;
    logic [1:0] pcs, cs, lds;
    logic       sts, s2m, hls;
    logic [5:0] stt;

    unidade_controle #(.MEM_WAIT(g + 1)) u_dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
      .overflow(overflow), .cond(cond),
      .PC_write(pcw), .A_write(aw), .B_write(bw), .EPC_write(epcw),
      .IRWrite(irw), .RegWrite(rgw), .MemWrite(mw), .FlagRegWrite(fw),
      .HI_write(hw), .LO_write(low), .Seletor(sel), .seletor_ulaA(ua),
      .seletor_ulaB(ub), .RegDst(rd), .MemtoReg(m2r), .ShiftOP(sop),
      .SrInputSrc(sri), .SrNSrc(srn), .IorD(iord), .PCSource(pcs),
      .conSrc(cs), .load_size(lds), .store_size(sts), .SrctoMem(s2m),
      .HiLoSrc(hls), .state(stt)
    );

    assign act[g] = {pcw, aw, bw, epcw, irw, rgw, mw, fw, hw, low, sel, ua, ub,
                     rd, m2r, sop, sri, srn, iord, pcs, cs, lds, sts, s2m, hls};
    assign st[g]  = stt;
  end

  // Expected control word for each state; arg is cond (branches),
  // overflow-suppressed RegWrite (add/addi) or overflow cause (EXC_RD)
  function automatic ctl_t exp_of(input int code, input logic arg);
    ctl_t r;
    r = '0;
    case (code)
      E_LATCH:  begin r.ir_w = 1'b1; r.pc_w = 1'b1; r.ula_b = 2'd1; r.sel = 3'b001; end
      E_DECODE: begin r.a_w = 1'b1; r.b_w = 1'b1; end
      E_ADD:    begin r.ula_a = 1'b1; r.sel = 3'b001; r.reg_w = ~arg; r.reg_dst = 3'd1; end
      E_SUB:    begin r.ula_a = 1'b1; r.sel = 3'b010; r.reg_w = 1'b1; r.reg_dst = 3'd1; end
      E_SLT:    begin r.ula_a = 1'b1; r.sel = 3'b111; r.m2r = 4'd9; r.reg_w = 1'b1; r.reg_dst = 3'd1; end
      E_JR:     begin r.ula_a = 1'b1; r.pc_w = 1'b1; end
      E_SHLOAD: r.sh_op = 3'b001;
      E_SLL:    r.sh_op = 3'b010;
      E_SRL:    r.sh_op = 3'b011;
      E_SRA:    r.sh_op = 3'b100;
      E_SHWB:   begin r.m2r = 4'd5; r.reg_dst = 3'd1; r.reg_w = 1'b1; end
      E_ADDI:   begin r.ula_a = 1'b1; r.ula_b = 2'd2; r.sel = 3'b001; r.reg_w = ~arg; end
      E_LUI:    begin r.m2r = 4'd7; r.reg_w = 1'b1; end
      E_LWA:    begin r.ula_a = 1'b1; r.ula_b = 2'd2; r.sel = 3'b001; r.iord = 3'd1; end
      E_LWWB:   begin r.ula_a = 1'b1; r.ula_b = 2'd2; r.sel = 3'b001; r.iord = 3'd1;
                      r.m2r = 4'd1; r.reg_w = 1'b1; end
      E_SW:     begin r.ula_a = 1'b1; r.ula_b = 2'd2; r.sel = 3'b001; r.iord = 3'd1; r.mem_w = 1'b1; end
      E_BRCMP:  begin r.ula_a = 1'b1; r.sel = 3'b111; r.flag_w = 1'b1; end
      E_BEQ:    begin r.ula_b = 2'd3; r.sel = 3'b001; r.consrc = 2'd0; r.pc_w = arg; end
      E_BNE:    begin r.ula_b = 2'd3; r.sel = 3'b001; r.consrc = 2'd1; r.pc_w = arg; end
      E_J:      begin r.pcsrc = 2'd1; r.pc_w = 1'b1; end
      E_EPC:    begin r.ula_b = 2'd1; r.sel = 3'b010; r.epc_w = 1'b1; end
      E_RD:     r.iord = arg ? 3'd3 : 3'd2;
      E_EJMP:   begin r.ld_size = 2'd2; r.pcsrc = 2'd2; r.pc_w = 1'b1; end
      default:  r = '0;
    endcase
    return r;
  endfunction

  vec_t       q[$];
  int         n_vec = 0;
  int         n_bad = 0;
  int         n_seq = 0;
  logic       cur_rst = 1'b1;
  logic [5:0] cur_op = 6'h00;
  logic [5:0] cur_fn = 6'h00;
  logic       cur_cnd = 1'b0;
  logic       cur_ovf = 1'b0;
  logic [1:0] cur_inst = 2'd0;

  task automatic v(input int code, input logic arg, input logic [1:0] sm);
    vec_t x;
    x.rst = cur_rst; x.op = cur_op; x.fn = cur_fn; x.cnd = cur_cnd;
    x.ovf = cur_ovf; x.inst = cur_inst; x.e = exp_of(code, arg); x.sm = sm;
    q.push_back(x);
  endtask

  // Latch + decode cycles common to every instruction
  task automatic ins(input logic [5:0] op, input logic [5:0] fn);
    cur_op = op; cur_fn = fn;
    v(E_LATCH, 1'b0, 2'd0);
    v(E_DECODE, 1'b0, 2'd0);
  endtask

  task automatic fetch_back();
    v(E_ZERO, 1'b0, 2'd2);
  endtask

  // Apply queued vectors one clock each and compare away from the edge
  task automatic run();
    logic bad;
    for (int i = 0; i < q.size(); i++) begin
      reset = q[i].rst; opcode = q[i].op; funct = q[i].fn;
      cond = q[i].cnd; overflow = q[i].ovf;
      @(posedge clk);
      #1;
      bad = (act[q[i].inst] !== q[i].e);
      if (q[i].sm == 2'd1 && st[q[i].inst] !== 6'd0) bad = 1'b1;
      if (q[i].sm == 2'd2 && st[q[i].inst] === 6'd0) bad = 1'b1;
      n_vec++;
      if (bad) begin
        n_bad++;
        $display("FAIL seq%0d vec%0d inst%0d: got ctl=%h state=%0d, want ctl=%h (state rule %0d)",
                 n_seq, i, q[i].inst, act[q[i].inst], st[q[i].inst], q[i].e, q[i].sm);
      end
    end
    q.delete();
    n_seq++;
  endtask

  initial begin
    // ---------------- main table, MEM_WAIT = 1 instance ----------------
    cur_inst = 2'd0;
    cur_rst = 1'b1; v(E_ZERO, 1'b0, 2'd1); v(E_ZERO, 1'b0, 2'd1);
    cur_rst = 1'b0; fetch_back();
    ins(6'h00, 6'h20); v(E_ADD, 1'b0, 2'd0); fetch_back();
    ins(6'h00, 6'h22); v(E_SUB, 1'b0, 2'd0); fetch_back();
    ins(6'h00, 6'h2a); v(E_SLT, 1'b0, 2'd0); fetch_back();
    ins(6'h00, 6'h08); v(E_JR, 1'b0, 2'd0); fetch_back();
    ins(6'h00, 6'h00); v(E_SHLOAD, 1'b0, 2'd0); v(E_SLL, 1'b0, 2'd0); v(E_SHWB, 1'b0, 2'd0); fetch_back();
    ins(6'h00, 6'h02); v(E_SHLOAD, 1'b0, 2'd0); v(E_SRL, 1'b0, 2'd0); v(E_SHWB, 1'b0, 2'd0); fetch_back();
    ins(6'h00, 6'h03); v(E_SHLOAD, 1'b0, 2'd0); v(E_SRA, 1'b0, 2'd0); v(E_SHWB, 1'b0, 2'd0); fetch_back();
    ins(6'h08, 6'h15); v(E_ADDI, 1'b0, 2'd0); fetch_back();
    ins(6'h0f, 6'h00); v(E_LUI, 1'b0, 2'd0); fetch_back();
    ins(6'h2b, 6'h04); v(E_SW, 1'b0, 2'd0); fetch_back();
    ins(6'h23, 6'h00); v(E_LWA, 1'b0, 2'd0); v(E_LWWB, 1'b0, 2'd0); fetch_back();
    cur_cnd = 1'b1;
    ins(6'h04, 6'h00); v(E_BRCMP, 1'b0, 2'd0); v(E_BEQ, 1'b1, 2'd0); fetch_back();
    cur_cnd = 1'b0;
    ins(6'h04, 6'h00); v(E_BRCMP, 1'b0, 2'd0); v(E_BEQ, 1'b0, 2'd0); fetch_back();
    cur_cnd = 1'b1;
    ins(6'h05, 6'h00); v(E_BRCMP, 1'b0, 2'd0); v(E_BNE, 1'b1, 2'd0); fetch_back();
    cur_cnd = 1'b0;
    ins(6'h02, 6'h00); v(E_J, 1'b0, 2'd0); fetch_back();
`ifdef UNIDADE_CONTROLE_EXC_EN
    ins(6'h3f, 6'h00); v(E_EPC, 1'b0, 2'd0); v(E_RD, 1'b0, 2'd0); v(E_EJMP, 1'b0, 2'd0); fetch_back();
    ins(6'h00, 6'h3f); v(E_EPC, 1'b0, 2'd0); v(E_RD, 1'b0, 2'd0); v(E_EJMP, 1'b0, 2'd0); fetch_back();
    ins(6'h00, 6'h20);
    cur_ovf = 1'b1; v(E_ADD, 1'b1, 2'd0); v(E_EPC, 1'b0, 2'd0);
    cur_ovf = 1'b0; v(E_RD, 1'b1, 2'd0); v(E_EJMP, 1'b0, 2'd0); fetch_back();
    ins(6'h08, 6'h00);
    cur_ovf = 1'b1; v(E_ADDI, 1'b1, 2'd0); v(E_EPC, 1'b0, 2'd0);
    cur_ovf = 1'b0; v(E_RD, 1'b1, 2'd0); v(E_EJMP, 1'b0, 2'd0); fetch_back();
`else
    ins(6'h3f, 6'h00); fetch_back();
    ins(6'h00, 6'h3f); fetch_back();
    ins(6'h00, 6'h20);
    cur_ovf = 1'b1; v(E_ADD, 1'b0, 2'd0); fetch_back();
    cur_ovf = 1'b0;
`endif
    run();

    // ---------------- reset held 3 cycles in the middle of lw ----------------
    cur_inst = 2'd0; cur_op = 6'h23; cur_fn = 6'h00;
    cur_rst = 1'b1; v(E_ZERO, 1'b0, 2'd1);
    cur_rst = 1'b0; fetch_back();
    v(E_LATCH, 1'b0, 2'd0); v(E_DECODE, 1'b0, 2'd0); v(E_LWA, 1'b0, 2'd0);
    cur_rst = 1'b1; v(E_ZERO, 1'b0, 2'd1); v(E_ZERO, 1'b0, 2'd1); v(E_ZERO, 1'b0, 2'd1);
    cur_rst = 1'b0; fetch_back(); v(E_LATCH, 1'b0, 2'd0);
    run();

    // ---------------- add with MEM_WAIT = 3: six cycles FETCH..R_EXE ----------------
    cur_inst = 2'd2; cur_op = 6'h00; cur_fn = 6'h20;
    cur_rst = 1'b1; v(E_ZERO, 1'b0, 2'd1);
    cur_rst = 1'b0; fetch_back(); fetch_back(); fetch_back();
    v(E_LATCH, 1'b0, 2'd0); v(E_DECODE, 1'b0, 2'd0); v(E_ADD, 1'b0, 2'd0); fetch_back();
    run();

    // ---------------- lw with MEM_WAIT = 2: LW_ADDR held two cycles ----------------
    cur_inst = 2'd1; cur_op = 6'h23; cur_fn = 6'h00;
    cur_rst = 1'b1; v(E_ZERO, 1'b0, 2'd1);
    cur_rst = 1'b0; fetch_back(); fetch_back();
    v(E_LATCH, 1'b0, 2'd0); v(E_DECODE, 1'b0, 2'd0);
    v(E_LWA, 1'b0, 2'd0); v(E_LWA, 1'b0, 2'd0); v(E_LWWB, 1'b0, 2'd0);
    fetch_back(); fetch_back();
    run();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
